// File: rtl/pmod_8led2_pattern.sv
// LED pattern generator for a PMOD 8LED2 board: four button-selected modes
// (static, binary count, bouncing scan, bar fill) stepped by a prescaler.
module pmod_8led2_pattern #(
    parameter int unsigned DIV = 2500000
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic       btn_mode,
    output logic [7:0] pmodledg,
    output logic [7:0] pmodledr,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        M_STATIC = 2'd0,
        M_COUNT  = 2'd1,
        M_SCAN   = 2'd2,
        M_FILL   = 2'd3
    } mode_e;

    localparam logic [7:0]  STATIC_G = 8'b10101001;
    localparam logic [7:0]  STATIC_R = 8'b01010010;
    localparam logic [23:0] LAST     = 24'(DIV - 1);

    logic        sync1_q, sync2_q, prev_q, adv_q, armed_q;
    logic [1:0]  warm_q;
    logic [23:0] presc_q, presc_d;
    mode_e       mode_q, mode_d;
    logic [7:0]  count_q, count_d, pos_q, pos_d;
    logic        dir_q, dir_d;
    logic [3:0]  level_q, level_d;
    logic [7:0]  led_g_q, led_g_d, led_r_q, led_r_d;
    logic [7:0]  pos_rev, fill_mask;
    logic        step;

    // armed_q blocks a press until the synchronised button has been seen low
    // after reset, so a button held through reset never counts as a press.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            adv_q   <= 1'b0;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= btn_mode;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            warm_q  <= {warm_q[0], 1'b1};
            armed_q <= armed_q | (warm_q[1] & ~sync2_q);
            adv_q   <= sync2_q & ~prev_q & armed_q;
        end
    end

    assign step = (presc_q == LAST);

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            mode_q  <= M_STATIC;
            count_q <= '0;
            pos_q   <= 8'h01;
            dir_q   <= 1'b0;
            level_q <= '0;
            led_g_q <= STATIC_G;
            led_r_q <= STATIC_R;
        end else begin
            presc_q <= presc_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            level_q <= level_d;
            led_g_q <= led_g_d;
            led_r_q <= led_r_d;
        end
    end

    // A mode change restarts everything and swallows a coincident step.
    always_comb begin
        presc_d = step ? '0 : presc_q + 24'd1;
        mode_d  = mode_q;
        count_d = count_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        level_d = level_q;
        if (adv_q) begin
            presc_d = '0;
            mode_d  = mode_e'(mode_q + 2'd1);
            count_d = '0;
            pos_d   = 8'h01;
            dir_d   = 1'b0;
            level_d = '0;
        end else if (step) begin
            case (mode_q)
                M_COUNT: count_d = count_q + 8'd1;
                M_SCAN: begin
                    if (!dir_q) begin
                        if (pos_q == 8'h80) begin
                            dir_d = 1'b1;
                            pos_d = 8'h40;
                        end else begin
                            pos_d = pos_q << 1;
                        end
                    end else begin
                        if (pos_q == 8'h01) begin
                            dir_d = 1'b0;
                            pos_d = 8'h02;
                        end else begin
                            pos_d = pos_q >> 1;
                        end
                    end
                end
                M_FILL:  level_d = (level_q == 4'd8) ? 4'd0 : level_q + 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        pos_rev = '0;
        for (int i = 0; i < 8; i++) pos_rev[i] = pos_q[7-i];
    end

    assign fill_mask = 8'((16'd1 << level_q) - 16'd1);

    always_comb begin
        led_g_d = STATIC_G;
        led_r_d = STATIC_R;
        case (mode_q)
            M_COUNT: begin
                led_g_d = count_q;
                led_r_d = ~count_q;
            end
            M_SCAN: begin
                led_g_d = pos_q;
                led_r_d = pos_rev;
            end
            M_FILL: begin
                led_g_d = fill_mask;
                led_r_d = ~fill_mask;
            end
            default: ;
        endcase
    end

    assign pmodledg = led_g_q;
    assign pmodledr = led_r_q;
    assign mode     = mode_q;

endmodule

// File: tb/tb_pmod_8led2_pattern.sv
// Bench for pmod_8led2_pattern (DIV=4): a negedge monitor pops expected LED
// pairs from a queue whenever the outputs change.
module tb_pmod_8led2_pattern;

    logic       clk, reset, btn;
    logic [7:0] g, r;
    logic [1:0] md;

    pmod_8led2_pattern #(.DIV(4)) dut (
        .clk_25mhz(clk),
        .reset    (reset),
        .btn_mode (btn),
        .pmodledg (g),
        .pmodledr (r),
        .mode     (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic [7:0]  last_g = 8'h00, last_r = 8'h00;

    always @(negedge clk) begin
        logic [15:0] e;
        if (mon_en && !reset && {g, r} !== {last_g, last_r}) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got g=%h r=%h, no value expected", g, r);
            end else begin
                e = exp_q.pop_front();
                if ({g, r} !== e) begin
                    errors++;
                    $display("FAIL sb_pattern: got g=%h r=%h, required g=%h r=%h", g, r, e[15:8], e[7:0]);
                end
            end
        end
        last_g <= g;
        last_r <= r;
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[i] = v[7-i];
        return o;
    endfunction

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Returns on the first negedge where mode has changed (before the LEDs follow).
    task automatic press();
        logic [1:0] m0;
        logic       ok;
        m0 = md;
        ok = 1'b0;
        @(negedge clk);
        btn = 1'b1;
        for (int n = 0; n < 12 && !ok; n++) begin
            @(negedge clk);
            if (md !== m0) ok = 1'b1;
        end
        btn = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL press: mode stayed %0d, required a change within 12 clocks", m0);
        end
    endtask

    task automatic reach(input int target);
        for (int i = 0; i < target; i++) begin
            if (i != 0) repeat (3) @(negedge clk);
            press();
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected values never seen, required 0", name, exp_q.size());
        end
        exp_q.delete();
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (g !== 8'hA9) begin errors++; $display("FAIL reset_g: got %h required a9", g); end
        if (r !== 8'h52) begin errors++; $display("FAIL reset_r: got %h required 52", r); end
        if (md !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d required 0", md); end
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        checks += 3;
        if (g !== 8'hA9) begin errors++; $display("FAIL idle_g: got %h required a9", g); end
        if (r !== 8'h52) begin errors++; $display("FAIL idle_r: got %h required 52", r); end
        if (md !== 2'd0) begin errors++; $display("FAIL idle_mode: got %0d required 0", md); end
    endtask

    task automatic test_count();
        logic [7:0] v;
        do_reset();
        reach(1);
        for (int k = 0; k <= 256; k++) begin
            v = 8'(k);
            exp_q.push_back({v, ~v});
        end
        mon_en = 1'b1;
        drain(257 * 4 + 40, "count");
    endtask

    task automatic test_scan();
        logic [7:0] v;
        do_reset();
        reach(2);
        for (int i = 0; i < 8; i++) begin
            v = 8'(1 << i);
            exp_q.push_back({v, rev8(v)});
        end
        for (int i = 6; i >= 0; i--) begin
            v = 8'(1 << i);
            exp_q.push_back({v, rev8(v)});
        end
        exp_q.push_back({8'h02, 8'h40});
        mon_en = 1'b1;
        drain(16 * 4 + 40, "scan");
        checks++;
        if (rev8(8'h80) !== 8'h01) begin errors++; $display("FAIL scan_r_at_80: model gave %h required 01", rev8(8'h80)); end
    endtask

    task automatic test_fill();
        logic [7:0] v;
        do_reset();
        reach(3);
        for (int l = 0; l <= 9; l++) begin
            v = (l == 9) ? 8'h00 : 8'((16'd1 << l) - 16'd1);
            exp_q.push_back({v, ~v});
        end
        mon_en = 1'b1;
        drain(10 * 4 + 40, "fill");
    endtask

    task automatic test_collision();
        logic [7:0] g0;
        int         n;
        do_reset();
        reach(1);
        // mode changed at edge A; steps fall on A+4k, so this press lands on A+12
        repeat (7) @(negedge clk);
        press();
        @(negedge clk);
        checks += 3;
        if (md !== 2'd2) begin errors++; $display("FAIL coll_mode: got %0d required 2", md); end
        if (g !== 8'h01) begin errors++; $display("FAIL coll_g: got %h required 01", g); end
        if (r !== 8'h80) begin errors++; $display("FAIL coll_r: got %h required 80", r); end
        g0 = g;
        n = 0;
        while (g === g0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks += 2;
        if (n != 4) begin errors++; $display("FAIL coll_step_gap: got %0d clocks required 4", n); end
        if (g !== 8'h02) begin errors++; $display("FAIL coll_first_step: got %h required 02", g); end
        repeat (3) @(negedge clk);
        press();
        repeat (3) @(negedge clk);
        press();
        @(negedge clk);
        checks += 3;
        if (md !== 2'd0) begin errors++; $display("FAIL wrap_mode: got %0d required 0", md); end
        if (g !== 8'hA9) begin errors++; $display("FAIL wrap_g: got %h required a9", g); end
        if (r !== 8'h52) begin errors++; $display("FAIL wrap_r: got %h required 52", r); end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        do_reset();
        reach(2);
        n = 0;
        while (g !== 8'h10 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (g !== 8'h10) begin errors++; $display("FAIL midscan_reach: got %h required 10", g); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (g !== 8'hA9) begin errors++; $display("FAIL midscan_g: got %h required a9", g); end
        if (r !== 8'h52) begin errors++; $display("FAIL midscan_r: got %h required 52", r); end
        if (md !== 2'd0) begin errors++; $display("FAIL midscan_mode: got %0d required 0", md); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_held_through_reset();
        btn = 1'b1;
        do_reset();
        repeat (20) @(negedge clk);
        checks++;
        if (md !== 2'd0) begin errors++; $display("FAIL held_btn_mode: got %0d required 0", md); end
        btn = 1'b0;
        repeat (5) @(negedge clk);
        press();
        checks++;
        if (md !== 2'd1) begin errors++; $display("FAIL repress_mode: got %0d required 1", md); end
    endtask

    initial begin
        reset = 1'b0;
        btn   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_count();
        test_scan();
        test_fill();
        test_collision();
        test_reset_mid_scan();
        test_held_through_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
